// File: rtl/bpu_gshare.sv
// bpu_gshare: gshare branch predictor for the decode stage.
//   Conditional branches (bxx) are predicted from a table of 2-bit saturating
//   counters indexed by pc XOR global history (GHR). jal/jalr are always
//   predicted taken. Execute trains the counters and repairs the GHR on a
//   mispredict. Prediction outputs are combinational in the decode cycle.
// Optional feature macro: BPU_RAS_EN enables a return-address stack that
//   pushes call return addresses and predicts jalr returns from its top.
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_stop, i_flush, i_vld   decode qualifiers (speculative update gating)
//   i_pc, i_imm              instruction address and offset
//   i_inst_jal/jalr/bxx      decoded instruction type (one-hot or zero)
//   i_inst_rdidx/rs1idx      register indices (used only for RAS)
//   i_jalr_rs1ren/rs1rdata   jalr base register availability and value
//   o_prdt_taken/pc/ghr      prediction and history checkpoint
//   i_upd_*                  resolved-branch training and GHR repair
module bpu_gshare #(
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned GHR_LEN   = 6,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_stop,
    input  logic                 i_flush,
    input  logic                 i_vld,
    input  logic [31:0]          i_pc,
    input  logic                 i_inst_jal,
    input  logic                 i_inst_jalr,
    input  logic                 i_inst_bxx,
    input  logic [4:0]           i_inst_rdidx,
    input  logic [4:0]           i_inst_rs1idx,
    input  logic [31:0]          i_imm,
    input  logic                 i_jalr_rs1ren,
    input  logic [31:0]          i_jalr_rs1rdata,
    output logic                 o_prdt_taken,
    output logic [31:0]          o_prdt_pc,
    output logic [GHR_LEN-1:0]   o_prdt_ghr,
    input  logic                 i_upd_vld,
    input  logic [31:0]          i_upd_pc,
    input  logic [GHR_LEN-1:0]   i_upd_ghr,
    input  logic                 i_upd_taken,
    input  logic                 i_upd_mispred
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]         bht [BHT_DEPTH];
    logic [GHR_LEN-1:0] ghr;
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   upd_idx;
    logic               bxx_taken;
    logic               spec;
    logic [31:0]        pc_plus4;
    logic [31:0]        br_tgt;
    logic [31:0]        jalr_sum;
    logic [31:0]        jalr_tgt;
    logic               ras_hit;
    logic [31:0]        ras_top;
    logic               unused_bits;

    // gshare index: pc word bits folded with zero-extended history
    assign rd_idx    = i_pc[IDX_W+1:2] ^ IDX_W'(ghr);
    assign upd_idx   = i_upd_pc[IDX_W+1:2] ^ IDX_W'(i_upd_ghr);
    assign bxx_taken = bht[rd_idx][1];
    assign spec      = i_vld & ~i_stop & ~i_flush;

    assign pc_plus4  = i_pc + 32'd4;
    assign br_tgt    = i_pc + i_imm;
    assign jalr_sum  = (i_jalr_rs1ren ? i_jalr_rs1rdata : 32'd0) + i_imm;
    assign jalr_tgt  = {jalr_sum[31:1], 1'b0};

    assign o_prdt_ghr = ghr;

    // Prediction select
    always_comb begin
        o_prdt_taken = 1'b0;
        o_prdt_pc    = pc_plus4;
        if (i_inst_jal) begin
            o_prdt_taken = 1'b1;
            o_prdt_pc    = br_tgt;
        end else if (i_inst_jalr) begin
            o_prdt_taken = 1'b1;
            o_prdt_pc    = ras_hit ? ras_top : jalr_tgt;
        end else if (i_inst_bxx && bxx_taken) begin
            o_prdt_taken = 1'b1;
            o_prdt_pc    = br_tgt;
        end
    end

    // Counter training; the read above sees the pre-update value
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (i_upd_vld) begin
            if (i_upd_taken) begin
                if (bht[upd_idx] != 2'b11) begin
                    bht[upd_idx] <= bht[upd_idx] + 2'b01;
                end
            end else if (bht[upd_idx] != 2'b00) begin
                bht[upd_idx] <= bht[upd_idx] - 2'b01;
            end
        end
    end

    // GHR: repair from execute has priority over the speculative shift
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ghr <= '0;
        end else if (i_upd_vld && i_upd_mispred) begin
            ghr <= GHR_LEN'({i_upd_ghr, i_upd_taken});
        end else if (spec && i_inst_bxx) begin
            ghr <= GHR_LEN'({ghr, bxx_taken});
        end
    end

`ifdef BPU_RAS_EN
    localparam int unsigned RAS_PW = $clog2(RAS_DEPTH);
    localparam int unsigned RAS_CW = $clog2(RAS_DEPTH + 1);

    logic [31:0]       ras [RAS_DEPTH];
    logic [RAS_PW-1:0] ras_sp;       // next free slot; top is ras_sp-1
    logic [RAS_CW-1:0] ras_cnt;
    logic [RAS_PW-1:0] top_ptr;
    logic              rd_link;
    logic              rs1_link;
    logic              is_call;
    logic              is_ret;
    logic              do_push;
    logic              do_pop;

    assign rd_link  = (i_inst_rdidx == 5'd1) || (i_inst_rdidx == 5'd5);
    assign rs1_link = (i_inst_rs1idx == 5'd1) || (i_inst_rs1idx == 5'd5);
    assign is_call  = (i_inst_jal | i_inst_jalr) & rd_link;
    assign is_ret   = i_inst_jalr & rs1_link &
                      ((i_inst_rs1idx != i_inst_rdidx) | ~rd_link);
    assign top_ptr  = ras_sp - RAS_PW'(1);
    assign ras_top  = ras[top_ptr];
    assign ras_hit  = is_ret & (ras_cnt != '0);
    assign do_pop   = spec & ras_hit;
    assign do_push  = spec & is_call;

    // Circular stack: a push when full overwrites the oldest entry
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ras_sp  <= '0;
            ras_cnt <= '0;
        end else if (do_pop && do_push) begin
            ras[top_ptr] <= pc_plus4;
        end else if (do_push) begin
            ras[ras_sp] <= pc_plus4;
            ras_sp      <= ras_sp + RAS_PW'(1);
            if (ras_cnt != RAS_CW'(RAS_DEPTH)) begin
                ras_cnt <= ras_cnt + RAS_CW'(1);
            end
        end else if (do_pop) begin
            ras_sp  <= top_ptr;
            ras_cnt <= ras_cnt - RAS_CW'(1);
        end
    end

    assign unused_bits = ^{i_upd_pc[31:IDX_W+2], i_upd_pc[1:0]};
`else
    assign ras_hit     = 1'b0;
    assign ras_top     = 32'd0;
    assign unused_bits = ^{i_upd_pc[31:IDX_W+2], i_upd_pc[1:0],
                           i_inst_rdidx, i_inst_rs1idx};
`endif

endmodule

// File: tb/tb_bpu_gshare.sv
// tb_bpu_gshare: self-checking bench for bpu_gshare with a behavioural model
// (counter array, integer history, queue-based return stack). Directed
// sequences pin literal expectations; a randomized phase follows.
// Feature macro honoured: BPU_RAS_EN.
module tb_bpu_gshare;

    localparam int unsigned BHT_DEPTH = 64;
    localparam int unsigned GHR_LEN   = 6;
    localparam int unsigned RAS_DEPTH = 4;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_stop, i_flush, i_vld;
    logic [31:0]        i_pc;
    logic               i_inst_jal, i_inst_jalr, i_inst_bxx;
    logic [4:0]         i_inst_rdidx, i_inst_rs1idx;
    logic [31:0]        i_imm;
    logic               i_jalr_rs1ren;
    logic [31:0]        i_jalr_rs1rdata;
    logic               o_prdt_taken;
    logic [31:0]        o_prdt_pc;
    logic [GHR_LEN-1:0] o_prdt_ghr;
    logic               i_upd_vld;
    logic [31:0]        i_upd_pc;
    logic [GHR_LEN-1:0] i_upd_ghr;
    logic               i_upd_taken, i_upd_mispred;

    bpu_gshare #(.BHT_DEPTH(BHT_DEPTH), .GHR_LEN(GHR_LEN), .RAS_DEPTH(RAS_DEPTH)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_stop(i_stop), .i_flush(i_flush),
        .i_vld(i_vld), .i_pc(i_pc), .i_inst_jal(i_inst_jal),
        .i_inst_jalr(i_inst_jalr), .i_inst_bxx(i_inst_bxx),
        .i_inst_rdidx(i_inst_rdidx), .i_inst_rs1idx(i_inst_rs1idx),
        .i_imm(i_imm), .i_jalr_rs1ren(i_jalr_rs1ren),
        .i_jalr_rs1rdata(i_jalr_rs1rdata), .o_prdt_taken(o_prdt_taken),
        .o_prdt_pc(o_prdt_pc), .o_prdt_ghr(o_prdt_ghr),
        .i_upd_vld(i_upd_vld), .i_upd_pc(i_upd_pc), .i_upd_ghr(i_upd_ghr),
        .i_upd_taken(i_upd_taken), .i_upd_mispred(i_upd_mispred)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int unsigned m_cnt [BHT_DEPTH];
    int unsigned m_ghr;
    logic [31:0] m_ras [$];
    bit          model_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic int unsigned m_index(input logic [31:0] pc, input int unsigned g);
        return ((int'(pc >> 2)) % BHT_DEPTH) ^ g;
    endfunction

    function automatic bit m_is_ret();
        return i_inst_jalr && is_link(i_inst_rs1idx) &&
               ((i_inst_rs1idx != i_inst_rdidx) || !is_link(i_inst_rdidx));
    endfunction

    function automatic bit m_is_call();
        return (i_inst_jal || i_inst_jalr) && is_link(i_inst_rdidx);
    endfunction

    // Expected prediction from the current inputs and model state
    function automatic void m_predict(output bit tk, output logic [31:0] npc);
        logic [31:0] base;
        tk  = 1'b0;
        npc = i_pc + 32'd4;
        if (i_inst_jal) begin
            tk  = 1'b1;
            npc = i_pc + i_imm;
        end else if (i_inst_jalr) begin
            tk   = 1'b1;
            base = i_jalr_rs1ren ? i_jalr_rs1rdata : 32'd0;
            npc  = (base + i_imm) & ~32'd1;
`ifdef BPU_RAS_EN
            if (m_is_ret() && m_ras.size() > 0) npc = m_ras[$];
`endif
        end else if (i_inst_bxx && m_cnt[m_index(i_pc, m_ghr)] >= 2) begin
            tk  = 1'b1;
            npc = i_pc + i_imm;
        end
    endfunction

    task automatic model_compare();
        bit          tk;
        logic [31:0] npc;
        if (model_ok) begin
            m_predict(tk, npc);
            chk("model_taken", 32'(o_prdt_taken), 32'(tk));
            chk("model_pc", o_prdt_pc, npc);
            chk("model_ghr", 32'(o_prdt_ghr), m_ghr);
        end
    endtask

    // Apply what the DUT sampled on this rising edge
    task automatic model_update();
        bit          pt;
        bit          spec;
        int unsigned ui;
        if (i_rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) m_cnt[i] = 1;
            m_ghr = 0;
            m_ras.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            pt   = m_cnt[m_index(i_pc, m_ghr)] >= 2;
            spec = i_vld && !i_stop && !i_flush;
`ifdef BPU_RAS_EN
            if (spec) begin
                if (m_is_ret() && m_ras.size() > 0) void'(m_ras.pop_back());
                if (m_is_call()) begin
                    m_ras.push_back(i_pc + 32'd4);
                    if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
                end
            end
`endif
            if (i_upd_vld) begin
                ui = m_index(i_upd_pc, int'(i_upd_ghr));
                if (i_upd_taken && m_cnt[ui] < 3) m_cnt[ui]++;
                else if (!i_upd_taken && m_cnt[ui] > 0) m_cnt[ui]--;
            end
            if (i_upd_vld && i_upd_mispred)
                m_ghr = ((int'(i_upd_ghr) << 1) | int'(i_upd_taken)) % (1 << GHR_LEN);
            else if (spec && i_inst_bxx)
                m_ghr = ((m_ghr << 1) | int'(pt)) % (1 << GHR_LEN);
        end
    endtask

    task automatic at_neg();
        @(negedge i_clk);
        model_compare();
    endtask

    task automatic at_pos();
        @(posedge i_clk);
        model_update();
        #1;
    endtask

    task automatic step();
        at_neg();
        at_pos();
    endtask

    task automatic set_idle();
        i_stop = 0; i_flush = 0; i_vld = 0;
        i_inst_jal = 0; i_inst_jalr = 0; i_inst_bxx = 0;
        i_inst_rdidx = 0; i_inst_rs1idx = 0;
        i_pc = 32'h0; i_imm = 32'h0;
        i_jalr_rs1ren = 0; i_jalr_rs1rdata = 32'h0;
        i_upd_vld = 0; i_upd_pc = 32'h0; i_upd_ghr = '0;
        i_upd_taken = 0; i_upd_mispred = 0;
    endtask

    task automatic set_bxx(input logic [31:0] pc, input logic [31:0] imm);
        set_idle();
        i_vld = 1; i_inst_bxx = 1; i_pc = pc; i_imm = imm;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd1;
            2:       return 5'd5;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    logic [31:0] ret_exp [5];

    initial begin
        set_idle();
        i_rst = 1;
        step();
        step();
        i_rst = 0;

        // Reset state: weakly not-taken, history zero
        set_bxx(32'h100, 32'h20);
        at_neg();
        chk("rst_taken", 32'(o_prdt_taken), 32'd0);
        chk("rst_pc", o_prdt_pc, 32'h104);
        chk("rst_ghr", 32'(o_prdt_ghr), 32'd0);
        at_pos();

        // Two taken updates make idx 0 strongly taken
        set_idle();
        i_upd_vld = 1; i_upd_pc = 32'h100; i_upd_ghr = '0; i_upd_taken = 1;
        step();
        step();

        // Stalled / flushed taken bxx must not shift history
        set_bxx(32'h100, 32'h20);
        i_stop = 1;
        at_neg();
        chk("trained_taken", 32'(o_prdt_taken), 32'd1);
        chk("trained_pc", o_prdt_pc, 32'h120);
        at_pos();
        i_stop = 0; i_flush = 1;
        at_neg();
        chk("stop_ghr", 32'(o_prdt_ghr), 32'd0);
        at_pos();
        set_idle();
        at_neg();
        chk("flush_ghr", 32'(o_prdt_ghr), 32'd0);
        at_pos();

        // Four not-taken updates: 11->10->01->00->00
        i_upd_vld = 1; i_upd_pc = 32'h100; i_upd_ghr = '0; i_upd_taken = 0;
        repeat (4) step();
        set_bxx(32'h100, 32'h20);
        i_stop = 1;
        at_neg();
        chk("sat_low_taken", 32'(o_prdt_taken), 32'd0);
        chk("sat_low_pc", o_prdt_pc, 32'h104);
        at_pos();

        // Three not-taken spec predictions, then repair beats the shift
        set_bxx(32'h100, 32'h20);
        for (int k = 0; k < 3; k++) begin
            at_neg();
            chk("spec_ghr", 32'(o_prdt_ghr), 32'd0);
            at_pos();
        end
        i_upd_vld = 1; i_upd_pc = 32'h300; i_upd_ghr = 6'b000101;
        i_upd_taken = 0; i_upd_mispred = 1;
        step();
        set_idle();
        at_neg();
        chk("repair_ghr", 32'(o_prdt_ghr), 32'h0A);
        at_pos();

        // Call then return
        set_idle();
        i_vld = 1; i_inst_jal = 1; i_inst_rdidx = 5'd1; i_pc = 32'h200; i_imm = 32'h40;
        at_neg();
        chk("jal_taken", 32'(o_prdt_taken), 32'd1);
        chk("jal_pc", o_prdt_pc, 32'h240);
        at_pos();
        set_idle();
        i_vld = 1; i_inst_jalr = 1; i_inst_rdidx = 5'd0; i_inst_rs1idx = 5'd1;
        i_pc = 32'h300; i_jalr_rs1ren = 1; i_jalr_rs1rdata = 32'h999;
        at_neg();
        chk("jalr_taken", 32'(o_prdt_taken), 32'd1);
`ifdef BPU_RAS_EN
        chk("ret_pc", o_prdt_pc, 32'h204);
`else
        chk("ret_pc", o_prdt_pc, 32'h998);
`endif
        at_pos();

        // Five calls into a 4-deep stack, then five returns
        for (int k = 1; k <= 5; k++) begin
            set_idle();
            i_vld = 1; i_inst_jal = 1; i_inst_rdidx = 5'd1;
            i_pc = 32'(k * 16); i_imm = 32'h80;
            step();
        end
`ifdef BPU_RAS_EN
        ret_exp = '{32'h54, 32'h44, 32'h34, 32'h24, 32'h998};
`else
        ret_exp = '{32'h998, 32'h998, 32'h998, 32'h998, 32'h998};
`endif
        for (int k = 0; k < 5; k++) begin
            set_idle();
            i_vld = 1; i_inst_jalr = 1; i_inst_rs1idx = 5'd1;
            i_pc = 32'h400; i_jalr_rs1ren = 1; i_jalr_rs1rdata = 32'h999;
            at_neg();
            chk("ras_pop_pc", o_prdt_pc, ret_exp[k]);
            at_pos();
        end

        // Stalled call must not push
        set_idle();
        i_vld = 1; i_stop = 1; i_inst_jal = 1; i_inst_rdidx = 5'd1; i_pc = 32'h500;
        step();
        set_idle();
        i_vld = 1; i_inst_jalr = 1; i_inst_rs1idx = 5'd5;
        i_pc = 32'h600; i_jalr_rs1ren = 1; i_jalr_rs1rdata = 32'h999;
        at_neg();
        chk("stop_nopush_pc", o_prdt_pc, 32'h998);
        at_pos();

        // Randomized phase
        for (int n = 0; n < 4000; n++) begin
            int t;
            set_idle();
            i_rst   = ($urandom_range(0, 299) == 0);
            i_stop  = ($urandom_range(0, 7) == 0);
            i_flush = ($urandom_range(0, 7) == 0);
            i_vld   = ($urandom_range(0, 3) != 0);
            t = $urandom_range(0, 6);
            i_inst_jal  = (t == 1);
            i_inst_jalr = (t == 2);
            i_inst_bxx  = (t >= 3);
            i_inst_rdidx    = pick_reg();
            i_inst_rs1idx   = pick_reg();
            i_pc            = 32'h1000 + 32'($urandom_range(0, 31) << 2);
            i_imm           = $urandom();
            i_jalr_rs1ren   = 1'($urandom_range(0, 1));
            i_jalr_rs1rdata = $urandom();
            i_upd_vld       = 1'($urandom_range(0, 1));
            i_upd_pc        = 32'h1000 + 32'($urandom_range(0, 31) << 2);
            i_upd_ghr       = GHR_LEN'($urandom_range(0, (1 << GHR_LEN) - 1));
            i_upd_taken     = 1'($urandom_range(0, 1));
            i_upd_mispred   = ($urandom_range(0, 2) == 0);
            step();
        end
        i_rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
